// File: rtl/alu_share_arb.sv
// Round-robin share of one single-cycle ALU between EX issue (port 0) and
// branch/address compute (port 1). Optional counters behind ALU_ARB_PERF_EN.
module alu_share_arb #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [11:0]      r0_op,
  input  logic [31:0]      r0_src1,
  input  logic [31:0]      r0_src2,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [11:0]      r1_op,
  input  logic [31:0]      r1_src1,
  input  logic [31:0]      r1_src2,
  input  logic [TAG_W-1:0] r1_tag,
  output logic [11:0]      alu_op,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_ARB_PERF_EN
  output logic [31:0]      perf_grant0,
  output logic [31:0]      perf_grant1,
  output logic [31:0]      perf_conflict,
`endif
  output logic [31:0]      out_result
);

  localparam int unsigned OP_W   = 12;
  localparam int unsigned DATA_W = 32;

  logic rr;
  logic can_accept;
  logic grant_vld;
  logic grant_id;
  logic fire;

  // Grant select, ready generation and ALU operand mux
  always_comb begin
    can_accept = ~out_valid | out_ready;
    grant_vld  = r0_valid | r1_valid;
    grant_id   = (r0_valid & r1_valid) ? rr : r1_valid;
    fire       = grant_vld & can_accept;
    r0_ready   = fire & ~grant_id;
    r1_ready   = fire & grant_id;
    alu_op     = OP_W'(0);
    alu_src1   = DATA_W'(0);
    alu_src2   = DATA_W'(0);
    if (grant_vld) begin
      // Operands follow the grant even when stalled, for stable waveforms
      if (grant_id) begin
        alu_op   = r1_op;
        alu_src1 = r1_src1;
        alu_src2 = r1_src2;
      end else begin
        alu_op   = r0_op;
        alu_src1 = r0_src1;
        alu_src2 = r0_src2;
      end
    end
  end

  // One-entry result register; refill on drain gives one result per cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      out_tag    <= TAG_W'(0);
      out_result <= DATA_W'(0);
      rr         <= 1'b0;
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_id     <= grant_id;
      out_tag    <= grant_id ? r1_tag : r0_tag;
      out_result <= alu_result;
      rr         <= ~grant_id;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Grant and contention counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_grant0   <= 32'd0;
      perf_grant1   <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (r0_valid & r0_ready) perf_grant0 <= perf_grant0 + 32'd1;
      if (r1_valid & r1_ready) perf_grant1 <= perf_grant1 + 32'd1;
      if (r0_valid & r1_valid & can_accept) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule
